// File: rtl/ssm_pkg.sv
// Shared types and lane helpers for the SSM group-reduction stage.
// Helpers work on a fixed MAX_W container so any lane width up to MAX_W can reuse them.
package ssm_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {ACC, FIN} acc_state_e;

  function automatic logic signed [MAX_W-1:0] sext_lane(input logic [MAX_W-1:0] v,
                                                        input int unsigned   w);
    logic signed [MAX_W-1:0] t;
    t = signed'(v << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

  // Low w bits of the result carry the narrowed value; ovf flags any out-of-range input.
  function automatic logic signed [MAX_W-1:0] sat_narrow(input  logic signed [MAX_W-1:0] s,
                                                         input  int unsigned            w,
                                                         input  logic                   sat,
                                                         output logic                   ovf);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi  = signed'((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    lo  = ~hi;
    ovf = (s > hi) || (s < lo);
    if (sat && (s > hi)) return hi;
    if (sat && (s < lo)) return lo;
    return s;
  endfunction

endpackage

// File: rtl/ssm_xd_fifo.sv
// Power-of-two synchronous FIFO holding one x*D vector per queued group.
module ssm_xd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ssm_group_accum.sv
// Sums a runtime-sized group of y_tile vectors, adds the group's queued x*D term and
// emits one narrowed result per group over ready/valid streams.
module ssm_group_accum
  import ssm_pkg::*;
#(
  parameter int DW        = 16,
  parameter int H_TILE    = 1,
  parameter int P_TILE    = 1,
  parameter int MAX_TILES = 16,
  parameter int ACC_W     = DW + 8,
  parameter int XD_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [$clog2(MAX_TILES+1)-1:0]     cfg_tiles_i,
  input  logic                               cfg_sat_i,
  input  logic                               tile_valid_i,
  output logic                               tile_ready_o,
  input  logic [H_TILE*P_TILE*DW-1:0]        y_tile_i,
  input  logic                               xd_valid_i,
  output logic                               xd_ready_o,
  input  logic [H_TILE*P_TILE*DW-1:0]        xd_i,
  output logic                               y_valid_o,
  input  logic                               y_ready_i,
  output logic [H_TILE*P_TILE*DW-1:0]        y_o,
  output logic                               ovf_o,
  output logic                               cfg_err_o
);

  localparam int LANES = H_TILE * P_TILE;
  localparam int CW    = $clog2(MAX_TILES + 1);

  if (ACC_W < DW + $clog2(MAX_TILES + 1) + 1) begin : g_bad_acc_w
    $error("ssm_group_accum: ACC_W too narrow for DW and MAX_TILES");
  end
  if (ACC_W > int'(MAX_W) || DW > int'(MAX_W)) begin : g_bad_max_w
    $error("ssm_group_accum: lane width exceeds ssm_pkg::MAX_W");
  end
  if (XD_DEPTH < 2 || (XD_DEPTH & (XD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ssm_group_accum: XD_DEPTH must be a power of two >= 2");
  end

  acc_state_e             state_q;
  acc_state_e             state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          target_q;
  logic                   sat_q;
  logic                   cfg_err_q;
  logic [LANES*DW-1:0]    y_q;
  logic                   y_valid_q;
  logic                   ovf_q;

  logic                   tile_ready;
  logic                   fin_go;
  logic                   tile_fire;
  logic                   first_tile;
  logic                   last_tile;
  logic                   cfg_bad;
  logic [CW-1:0]          cfg_clamped;
  logic [CW-1:0]          target;
  logic [LANES*DW-1:0]    y_next;
  logic [LANES-1:0]       lane_ovf;
  logic [LANES*DW-1:0]    xd_rdata;
  logic                   xd_full;
  logic                   xd_empty;

  ssm_xd_fifo #(
    .W     (LANES * DW),
    .DEPTH (XD_DEPTH)
  ) u_xd_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (xd_valid_i),
    .wdata_i (xd_i),
    .full_o  (xd_full),
    .pop_i   (fin_go),
    .rdata_o (xd_rdata),
    .empty_o (xd_empty)
  );

  // Out-of-range tile counts degrade to the nearest legal group size.
  always_comb begin
    cfg_bad     = 1'b0;
    cfg_clamped = cfg_tiles_i;
    if (cfg_tiles_i == '0) begin
      cfg_bad     = 1'b1;
      cfg_clamped = CW'(1);
    end else if (cfg_tiles_i > CW'(MAX_TILES)) begin
      cfg_bad     = 1'b1;
      cfg_clamped = CW'(MAX_TILES);
    end
  end

  assign tile_fire  = tile_valid_i && tile_ready;
  assign first_tile = (cnt_q == '0);
  assign target     = first_tile ? cfg_clamped : target_q;
  assign last_tile  = tile_fire && ((cnt_q + CW'(1)) == target);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ACC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (last_tile) state_d = FIN;
      FIN:     if (fin_go)    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // FIN may reload the output register in the same cycle it is being accepted.
  always_comb begin
    tile_ready = 1'b0;
    fin_go     = 1'b0;
    case (state_q)
      ACC:     tile_ready = 1'b1;
      FIN:     fin_go     = !xd_empty && (!y_valid_q || y_ready_i);
      default: tile_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      target_q  <= '0;
      sat_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (tile_fire) begin
      cnt_q <= last_tile ? '0 : cnt_q + CW'(1);
      if (first_tile) begin
        target_q <= cfg_clamped;
        sat_q    <= cfg_sat_i;
        if (cfg_bad) cfg_err_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic        [DW-1:0]    tile_lane;
    logic        [DW-1:0]    xd_lane;
    logic signed [ACC_W-1:0] tile_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [MAX_W-1:0] s_wide;
    logic        [DW-1:0]    y_lane;
    logic                    ovf_l;

    assign tile_lane = y_tile_i[DW*(k+1)-1 -: DW];
    assign xd_lane   = xd_rdata[DW*(k+1)-1 -: DW];
    assign tile_ext  = ACC_W'(sext_lane(MAX_W'(tile_lane), DW));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          acc_q <= '0;
      else if (tile_fire) acc_q <= first_tile ? tile_ext : acc_q + tile_ext;
    end

    always_comb begin
      ovf_l  = 1'b0;
      s_wide = sext_lane(MAX_W'(acc_q), ACC_W) + sext_lane(MAX_W'(xd_lane), DW);
      y_lane = DW'(sat_narrow(s_wide, DW, sat_q, ovf_l));
    end

    assign y_next[DW*(k+1)-1 -: DW] = y_lane;
    assign lane_ovf[k]              = ovf_l;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (fin_go) begin
      y_q       <= y_next;
      y_valid_q <= 1'b1;
      if (|lane_ovf) ovf_q <= 1'b1;
    end else if (y_ready_i) begin
      y_valid_q <= 1'b0;
    end
  end

  assign tile_ready_o = tile_ready;
  assign xd_ready_o   = !xd_full;
  assign y_valid_o    = y_valid_q;
  assign y_o          = y_q;
  assign ovf_o        = ovf_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_ssm_group_accum.sv
// Scenario bench for ssm_group_accum: expected group results are queued as stimulus is
// issued and compared by a monitor whenever an output handshake occurs.
module tb_ssm_group_accum;

  localparam int DW        = 16;
  localparam int H_TILE    = 1;
  localparam int P_TILE    = 2;
  localparam int LANES     = H_TILE * P_TILE;
  localparam int MAX_TILES = 16;
  localparam int ACC_W     = 24;
  localparam int XD_DEPTH  = 4;
  localparam int CW        = $clog2(MAX_TILES + 1);
  localparam int VW        = LANES * DW;

  logic          clk;
  logic          rstn;
  logic [CW-1:0] cfg_tiles_i;
  logic          cfg_sat_i;
  logic          tile_valid_i;
  logic          tile_ready_o;
  logic [VW-1:0] y_tile_i;
  logic          xd_valid_i;
  logic          xd_ready_o;
  logic [VW-1:0] xd_i;
  logic          y_valid_o;
  logic          y_ready_i;
  logic [VW-1:0] y_o;
  logic          ovf_o;
  logic          cfg_err_o;

  int            vectors;
  int            miscompares;
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] sb_exp;

  ssm_group_accum #(
    .DW(DW), .H_TILE(H_TILE), .P_TILE(P_TILE),
    .MAX_TILES(MAX_TILES), .ACC_W(ACC_W), .XD_DEPTH(XD_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_tiles_i(cfg_tiles_i), .cfg_sat_i(cfg_sat_i),
    .tile_valid_i(tile_valid_i), .tile_ready_o(tile_ready_o), .y_tile_i(y_tile_i),
    .xd_valid_i(xd_valid_i), .xd_ready_o(xd_ready_o), .xd_i(xd_i),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_o(y_o),
    .ovf_o(ovf_o), .cfg_err_o(cfg_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [VW-1:0] pack2(input int l0, input int l1);
    return {DW'(l1), DW'(l0)};
  endfunction

  // Output handshakes complete on the next rising edge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (rstn && y_valid_o && y_ready_i) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard_extra: got y_o=%h with nothing expected", y_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (y_o !== sb_exp) begin
          miscompares++;
          $display("[TB] FAIL scoreboard_y: got %h want %h", y_o, sb_exp);
        end
      end
    end
  end

  task automatic send_tile(input logic [VW-1:0] y);
    bit done;
    done         = 1'b0;
    tile_valid_i = 1'b1;
    y_tile_i     = y;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (tile_ready_o) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    #1 tile_valid_i = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL tile_accept: got no handshake want handshake within 300 cycles");
    end
  endtask

  task automatic send_xd(input logic [VW-1:0] xd);
    bit done;
    done       = 1'b0;
    xd_valid_i = 1'b1;
    xd_i       = xd;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (xd_ready_o) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    #1 xd_valid_i = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL xd_accept: got no handshake want handshake within 300 cycles");
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = y_valid_o;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_valid: got y_valid_o=0 want 1 within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d results pending want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    vectors += 6;
    if (tile_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tile_ready: got %b want 1", tile_ready_o); end
    if (xd_ready_o !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_xd_ready: got %b want 1", xd_ready_o); end
    if (y_valid_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_y_valid: got %b want 0", y_valid_o); end
    if (y_o !== '0)            begin miscompares++; $display("[TB] FAIL reset_y: got %h want 0", y_o); end
    if (ovf_o !== 1'b0)        begin miscompares++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf_o); end
    if (cfg_err_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_cfg_err: got %b want 0", cfg_err_o); end
  endtask

  task automatic test_basic();
    cfg_tiles_i = CW'(2);
    cfg_sat_i   = 1'b1;
    send_xd(pack2(3, 1));
    exp_q.push_back(pack2(123, -9));
    send_tile(pack2(100, -5));
    send_tile(pack2(20, -5));
    vectors += 2;
    if (tile_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_fin_ready: got %b want 0", tile_ready_o); end
    if (y_valid_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL basic_early_valid: got %b want 0", y_valid_o); end
    @(posedge clk); #1;
    vectors += 3;
    if (y_valid_o !== 1'b1)          begin miscompares++; $display("[TB] FAIL basic_latency: got y_valid=%b want 1", y_valid_o); end
    if (y_o !== pack2(123, -9))      begin miscompares++; $display("[TB] FAIL basic_y: got %h want %h", y_o, pack2(123, -9)); end
    if (ovf_o !== 1'b0)              begin miscompares++; $display("[TB] FAIL basic_ovf: got %b want 0", ovf_o); end
    @(posedge clk); #1;
    vectors++;
    if (y_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_valid_drop: got %b want 0", y_valid_o); end
  endtask

  task automatic test_sat_wrap();
    cfg_tiles_i = CW'(4);
    cfg_sat_i   = 1'b1;
    send_xd(pack2(0, 5));
    exp_q.push_back(pack2(32767, 32767));
    for (int i = 0; i < 4; i++) send_tile(pack2(28672, 28672));
    wait_valid();
    vectors++;
    if (ovf_o !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_ovf: got %b want 1", ovf_o); end
    wait_drain();
    // 0x1C000 + 16 and 0x1C000 - 1, keeping the low 16 bits.
    cfg_sat_i = 1'b0;
    send_xd(pack2(16, -1));
    exp_q.push_back({16'hBFFF, 16'hC010});
    for (int i = 0; i < 4; i++) send_tile(pack2(28672, 28672));
    wait_drain();
    vectors++;
    if (ovf_o !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_ovf: got %b want 1", ovf_o); end
  endtask

  task automatic test_xd_late();
    cfg_tiles_i = CW'(2);
    cfg_sat_i   = 1'b1;
    exp_q.push_back(pack2(-300, 400));
    send_tile(pack2(-100, 200));
    send_tile(pack2(-200, 150));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors += 2;
      if (tile_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL late_tile_ready: got %b want 0 at wait %0d", tile_ready_o, i); end
      if (y_valid_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL late_valid_early: got %b want 0 at wait %0d", y_valid_o, i); end
    end
    send_xd(pack2(0, 50));
    vectors++;
    if (y_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL late_push_visible: got %b want 0", y_valid_o); end
    @(posedge clk); #1;
    vectors++;
    if (y_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL late_valid: got %b want 1", y_valid_o); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    y_ready_i   = 1'b0;
    cfg_sat_i   = 1'b1;
    send_xd(pack2(1, 2));
    send_xd(pack2(5, 5));
    exp_q.push_back(pack2(41, 62));
    exp_q.push_back(pack2(8, 8));
    cfg_tiles_i = CW'(2);
    send_tile(pack2(10, 20));
    send_tile(pack2(30, 40));
    wait_valid();
    cfg_tiles_i = CW'(3);
    for (int i = 0; i < 3; i++) send_tile(pack2(1, 1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors += 2;
      if (y_o !== pack2(41, 62)) begin miscompares++; $display("[TB] FAIL bp_hold_y: got %h want %h", y_o, pack2(41, 62)); end
      if (y_valid_o !== 1'b1)    begin miscompares++; $display("[TB] FAIL bp_hold_valid: got %b want 1", y_valid_o); end
    end
    vectors++;
    if (tile_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_fin_stall: got tile_ready=%b want 0", tile_ready_o); end
    send_xd(pack2(0, 0));
    send_xd(pack2(1, 1));
    send_xd(pack2(2, 2));
    vectors++;
    if (xd_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_xd_full: got %b want 0", xd_ready_o); end
    y_ready_i   = 1'b1;
    cfg_tiles_i = CW'(1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack2(100 + i, -100 + i));
      send_tile(pack2(100, -100));
    end
    wait_drain();
  endtask

  task automatic test_cfg_err();
    cfg_sat_i   = 1'b1;
    cfg_tiles_i = CW'(0);
    send_xd(pack2(1, 1));
    exp_q.push_back(pack2(8, -6));
    send_tile(pack2(7, -7));
    vectors += 2;
    if (cfg_err_o !== 1'b1)    begin miscompares++; $display("[TB] FAIL cfg0_err: got %b want 1", cfg_err_o); end
    if (tile_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cfg0_one_tile: got tile_ready=%b want 0", tile_ready_o); end
    wait_drain();
    cfg_tiles_i = CW'(17);
    send_xd(pack2(0, 0));
    exp_q.push_back(pack2(16, 32));
    for (int i = 0; i < 16; i++) begin
      send_tile(pack2(1, 2));
      if (i == 14) begin
        vectors++;
        if (tile_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL cfg17_early_close: got tile_ready=%b want 1", tile_ready_o); end
      end
    end
    vectors++;
    if (tile_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cfg17_clamp: got tile_ready=%b want 0", tile_ready_o); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    cfg_tiles_i = CW'(3);
    cfg_sat_i   = 1'b1;
    send_tile(pack2(1000, 1000));
    #2 rstn = 1'b0;
    #1;
    vectors += 6;
    if (tile_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_tile_ready: got %b want 1", tile_ready_o); end
    if (xd_ready_o !== 1'b1)   begin miscompares++; $display("[TB] FAIL rst_xd_ready: got %b want 1", xd_ready_o); end
    if (y_valid_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_y_valid: got %b want 0", y_valid_o); end
    if (y_o !== '0)            begin miscompares++; $display("[TB] FAIL rst_y: got %h want 0", y_o); end
    if (ovf_o !== 1'b0)        begin miscompares++; $display("[TB] FAIL rst_ovf: got %b want 0", ovf_o); end
    if (cfg_err_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_cfg_err: got %b want 0", cfg_err_o); end
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    cfg_tiles_i = CW'(2);
    send_xd(pack2(1, 1));
    exp_q.push_back(pack2(13, 15));
    send_tile(pack2(5, 6));
    send_tile(pack2(7, 8));
    wait_drain();
    vectors++;
    if (ovf_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_clean_ovf: got %b want 0", ovf_o); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rstn         = 1'b0;
    cfg_tiles_i  = '0;
    cfg_sat_i    = 1'b0;
    tile_valid_i = 1'b0;
    y_tile_i     = '0;
    xd_valid_i   = 1'b0;
    xd_i         = '0;
    y_ready_i    = 1'b1;
    $display("[TB] starting ssm_group_accum scenarios");
    test_reset();
    test_basic();
    test_sat_wrap();
    test_xd_late();
    test_backpressure();
    test_cfg_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
